// File: rtl/rgb_rx.sv
// rgb_rx: parallel RGB video receiver.
//   Captures pixels framed by vsync/de, tags each one with its (x, y)
//   coordinate and start-of-frame / end-of-line / end-of-frame markers,
//   and flags malformed lines and frames.
// Ports:
//   clk                : sole clock, rising edge
//   reset              : synchronous, active-low
//   r, g, b            : incoming colour channels (COLOR_BITS each)
//   vsync, hsync, de   : active-high sync / data-enable
//   color              : captured pixel {r,g,b}
//   x, y               : coordinate of color
//   valid              : color/x/y hold a pixel this cycle
//   sof, eol, eof      : markers, only ever high together with valid
//   line_err, frame_err: one-cycle error pulses
//   locked             : high once a vsync rising edge has been seen
module rgb_rx #(
  parameter int X_WIDTH    = 64,
  parameter int Y_WIDTH    = 64,
  parameter int COLOR_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COLOR_BITS-1:0]        r,
  input  logic [COLOR_BITS-1:0]        g,
  input  logic [COLOR_BITS-1:0]        b,
  input  logic                         vsync,
  input  logic                         hsync,
  input  logic                         de,
  output logic [3*COLOR_BITS-1:0]      color,
  output logic [$clog2(X_WIDTH)-1:0]   x,
  output logic [$clog2(Y_WIDTH)-1:0]   y,
  output logic                         valid,
  output logic                         sof,
  output logic                         eol,
  output logic                         eof,
  output logic                         line_err,
  output logic                         frame_err,
  output logic                         locked
);

  localparam int XW = $clog2(X_WIDTH);
  localparam int YW = $clog2(Y_WIDTH);
  // Pixel counter must be able to hold X_WIDTH itself ("line full").
  localparam int CW = $clog2(X_WIDTH + 1);

  localparam logic [CW-1:0] X_FULL = CW'(X_WIDTH);
  localparam logic [CW-1:0] X_LAST = CW'(X_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ACTIVE,
    LINE_GAP,
    DROP
  } state_t;

  // Input stage
  logic [COLOR_BITS-1:0] r_q, g_q, b_q;
  logic                  vs_q, hs_q, de_q, vs_prev;

  // FSM and counters
  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [YW-1:0]         line_q, line_n;
  logic                  ovf, ovf_n;

  // Next values of registered outputs
  logic [3*COLOR_BITS-1:0] color_n;
  logic [XW-1:0]           x_n;
  logic [YW-1:0]           y_n;
  logic                    valid_n, sof_n, eol_n, eof_n;
  logic                    le_n, fe_n, locked_n;

  // Pixel emission request from the FSM
  logic                    pix_en, pix_sof;
  logic [CW-1:0]           pix_x;
  logic [YW-1:0]           pix_y;

  logic                    vs_rise;
  assign vs_rise = vs_q & ~vs_prev;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    line_n   = line_q;
    ovf_n    = ovf;
    color_n  = color;
    x_n      = x;
    y_n      = y;
    valid_n  = 1'b0;
    sof_n    = 1'b0;
    eol_n    = 1'b0;
    eof_n    = 1'b0;
    le_n     = 1'b0;
    fe_n     = 1'b0;
    locked_n = locked;
    pix_en   = 1'b0;
    pix_sof  = 1'b0;
    pix_x    = '0;
    pix_y    = '0;

    // hsync during a data cycle is a line error in any locked state.
    if (state != IDLE && hs_q && de_q) le_n = 1'b1;

    if (state == IDLE) begin
      if (vs_rise) begin
        state_n  = SYNC;
        locked_n = 1'b1;
        cnt_n    = '0;
        line_n   = '0;
        ovf_n    = 1'b0;
      end
    end else if (vs_rise) begin
      // vsync wins over de; a frame is complete only if the last line
      // ended (LINE_GAP) on line Y_WIDTH-1, or it was already overlong.
      state_n = SYNC;
      cnt_n   = '0;
      line_n  = '0;
      ovf_n   = 1'b0;
      x_n     = '0;
      y_n     = '0;
      if (state == ACTIVE) begin
        le_n = 1'b1;
        fe_n = 1'b1;
      end else if (state == SYNC || (state == LINE_GAP && line_q != Y_LAST)) begin
        fe_n = 1'b1;
      end
    end else begin
      case (state)
        SYNC: begin
          if (de_q) begin
            pix_en  = 1'b1;
            pix_sof = 1'b1;
            cnt_n   = CW'(1);
            ovf_n   = 1'b0;
            state_n = ACTIVE;
          end
        end
        ACTIVE: begin
          if (de_q) begin
            if (cnt != X_FULL) begin
              pix_en = 1'b1;
              pix_x  = cnt;
              pix_y  = line_q;
              cnt_n  = cnt + 1'b1;
            end else if (!ovf) begin
              // First excess pixel of a long line: report once, then
              // swallow the rest until de falls.
              le_n  = 1'b1;
              ovf_n = 1'b1;
            end
          end else begin
            state_n = LINE_GAP;
            if (cnt != X_FULL) le_n = 1'b1;
          end
        end
        LINE_GAP: begin
          if (de_q) begin
            if (line_q == Y_LAST) begin
              fe_n    = 1'b1;
              state_n = DROP;
            end else begin
              line_n  = line_q + 1'b1;
              pix_en  = 1'b1;
              pix_y   = line_q + 1'b1;
              cnt_n   = CW'(1);
              ovf_n   = 1'b0;
              state_n = ACTIVE;
            end
          end
        end
        default: ;  // DROP waits for vsync
      endcase
    end

    if (pix_en) begin
      valid_n = 1'b1;
      color_n = {r_q, g_q, b_q};
      x_n     = pix_x[XW-1:0];
      y_n     = pix_y;
      sof_n   = pix_sof;
      eol_n   = (pix_x == X_LAST);
      eof_n   = (pix_x == X_LAST) && (pix_y == Y_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      de_q      <= 1'b0;
      vs_prev   <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      line_q    <= '0;
      ovf       <= 1'b0;
      color     <= '0;
      x         <= '0;
      y         <= '0;
      valid     <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      locked    <= 1'b0;
    end else begin
      r_q       <= r;
      g_q       <= g;
      b_q       <= b;
      vs_q      <= vsync;
      hs_q      <= hsync;
      de_q      <= de;
      vs_prev   <= vs_q;
      state     <= state_n;
      cnt       <= cnt_n;
      line_q    <= line_n;
      ovf       <= ovf_n;
      color     <= color_n;
      x         <= x_n;
      y         <= y_n;
      valid     <= valid_n;
      sof       <= sof_n;
      eol       <= eol_n;
      eof       <= eof_n;
      line_err  <= le_n;
      frame_err <= fe_n;
      locked    <= locked_n;
    end
  end

endmodule
